// File: rtl/pio_hull_pkg.sv
// Shared definitions for the hull power-stage output PIO: register map and pulse FSM encoding.
package pio_hull_pkg;

    typedef logic [2:0] addr_t;

    localparam addr_t ADDR_DATA      = 3'd0;
    localparam addr_t ADDR_PULSE_LEN = 3'd1;
    localparam addr_t ADDR_PULSE_GO  = 3'd2;
    localparam addr_t ADDR_STATUS    = 3'd3;
    localparam addr_t ADDR_OUTSET    = 3'd4;
    localparam addr_t ADDR_OUTCLEAR  = 3'd5;

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] ACTIVE = 1'b1;

endpackage

// File: rtl/pio_hull_ctrl_if.sv
// Avalon-MM slave bus bundle for the hull control PIO.
interface pio_hull_ctrl_if;

    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );

endinterface

// File: rtl/pio_pulse_timer.sv
// One-shot pulse generator: a GO latches bits into pulse_mask and holds them for len cycles.
module pio_pulse_timer
    import pio_hull_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int LEN_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 go,
    input  logic [WIDTH-1:0]     go_bits,
    input  logic [LEN_WIDTH-1:0] len,
    output logic [WIDTH-1:0]     pulse_mask,
    output logic                 busy
);

    logic [0:0]           state;
    logic [LEN_WIDTH-1:0] count;
    logic                 go_ok;

    // A zero length or empty bit set is a no-op, even while a pulse is running.
    assign go_ok = go && (len != '0) && (go_bits != '0);
    assign busy  = (pulse_mask != '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            pulse_mask <= '0;
            count      <= '0;
        end else if (go_ok) begin
            // Retrigger extends every active bit; it also wins over the terminal count.
            state      <= ACTIVE;
            pulse_mask <= pulse_mask | go_bits;
            count      <= len;
        end else if (state == ACTIVE) begin
            if (count > LEN_WIDTH'(1)) begin
                count <= count - LEN_WIDTH'(1);
            end else begin
                state      <= IDLE;
                pulse_mask <= '0;
                count      <= '0;
            end
        end
    end

endmodule

// File: rtl/pio_hull_ctrl.sv
// Output PIO for the hull power stage: static data register, atomic set/clear and per-bit timed pulses.
module pio_hull_ctrl
    import pio_hull_pkg::*;
#(
    parameter int                   WIDTH       = 8,
    parameter logic [WIDTH-1:0]     RESET_VALUE = '0,
    parameter int                   LEN_WIDTH   = 16,
    parameter logic [LEN_WIDTH-1:0] DEFAULT_LEN = LEN_WIDTH'(100)
) (
    input  logic             clk,
    input  logic             reset_n,
    pio_hull_ctrl_if.slave   bus,
    output logic [WIDTH-1:0] out_port
);

    logic                 wr;
    logic [WIDTH-1:0]     wdata;
    logic [WIDTH-1:0]     data_reg;
    logic [LEN_WIDTH-1:0] len_reg;
    logic [WIDTH-1:0]     pulse_mask;
    logic                 busy;
    logic                 go;
    logic [31:0]          rd_mux;
    logic                 unused_wdata;

    assign wr    = bus.chipselect & ~bus.write_n;
    assign wdata = bus.writedata[WIDTH-1:0];
    assign go    = wr && (bus.address == ADDR_PULSE_GO);
    assign unused_wdata = ^bus.writedata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_reg <= RESET_VALUE;
        end else if (wr) begin
            case (bus.address)
                ADDR_DATA:     data_reg <= wdata;
                ADDR_OUTSET:   data_reg <= data_reg | wdata;
                ADDR_OUTCLEAR: data_reg <= data_reg & ~wdata;
                default:       ;
            endcase
        end
    end

    // A new length only applies to the next GO; the running count is owned by the timer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            len_reg <= DEFAULT_LEN;
        end else if (wr && (bus.address == ADDR_PULSE_LEN)) begin
            len_reg <= bus.writedata[LEN_WIDTH-1:0];
        end
    end

    pio_pulse_timer #(
        .WIDTH     (WIDTH),
        .LEN_WIDTH (LEN_WIDTH)
    ) u_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .go         (go),
        .go_bits    (wdata),
        .len        (len_reg),
        .pulse_mask (pulse_mask),
        .busy       (busy)
    );

    always_comb begin
        rd_mux = '0;
        case (bus.address)
            ADDR_DATA:      rd_mux[WIDTH-1:0]     = data_reg;
            ADDR_PULSE_LEN: rd_mux[LEN_WIDTH-1:0] = len_reg;
            ADDR_PULSE_GO:  rd_mux[WIDTH-1:0]     = pulse_mask;
            ADDR_STATUS:    rd_mux[0]             = busy;
            default:        ;
        endcase
    end

    // Reads are side-effect free, so readdata simply tracks the mux every cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.readdata <= '0;
        end else begin
            bus.readdata <= rd_mux;
        end
    end

    assign out_port = data_reg | pulse_mask;

endmodule
